// File: rtl/pc_unit_pkg.sv
// Shared core definitions for the program-counter unit: FSM states,
// instruction-alignment constants and the decoded RV32I base opcode set.
package pc_unit_pkg;

  localparam int unsigned IALIGN_16 = 16;
  localparam int unsigned IALIGN_32 = 32;

  typedef enum logic [1:0] {
    BOOT      = 2'd0,
    RUN       = 2'd1,
    TRAP_WAIT = 2'd2
  } pc_state_e;

  typedef enum logic [5:0] {
    INSTR_LUI, INSTR_AUIPC, INSTR_JAL, INSTR_JALR,
    INSTR_BEQ, INSTR_BNE, INSTR_BLT, INSTR_BGE, INSTR_BLTU, INSTR_BGEU,
    INSTR_LB, INSTR_LH, INSTR_LW, INSTR_LBU, INSTR_LHU,
    INSTR_SB, INSTR_SH, INSTR_SW,
    INSTR_ADDI, INSTR_SLTI, INSTR_SLTIU, INSTR_XORI, INSTR_ORI, INSTR_ANDI,
    INSTR_SLLI, INSTR_SRLI, INSTR_SRAI,
    INSTR_ADD, INSTR_SUB, INSTR_SLL, INSTR_SLT, INSTR_SLTU,
    INSTR_XOR, INSTR_SRL, INSTR_SRA, INSTR_OR, INSTR_AND,
    INSTR_FENCE, INSTR_ECALL, INSTR_EBREAK
  } rv32i_base_instr;

  // Low address bits that must be zero for a legal instruction address.
  function automatic logic [1:0] align_mask(input int unsigned ialign);
    return (ialign == IALIGN_16) ? 2'b01 : 2'b11;
  endfunction

endpackage

// File: rtl/pc_unit_target_calc.sv
// Combinational branch/jump resolution: taken decision, target address and
// target alignment check.
module pc_target_calc
  import pc_unit_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned IALIGN     = 32
) (
  input  logic [ADDR_WIDTH-1:0] pc_i,
  input  rv32i_base_instr       opcode_i,
  input  logic [DATA_WIDTH-1:0] imm_i,
  input  logic [DATA_WIDTH-1:0] alu_result_i,
  input  logic                  eq_i,
  input  logic                  lt_i,
  input  logic                  ltu_i,
  output logic                  taken_o,
  output logic [ADDR_WIDTH-1:0] target_o,
  output logic                  misaligned_o
);

  localparam logic [ADDR_WIDTH-1:0] BIT0 = ADDR_WIDTH'(1);

  logic [ADDR_WIDTH-1:0] imm_a;
  logic [ADDR_WIDTH-1:0] alu_a;

  // Immediate is sign-extended when narrower than the PC, truncated otherwise.
  generate
    if (DATA_WIDTH >= ADDR_WIDTH) begin : g_trunc
      assign imm_a = imm_i[ADDR_WIDTH-1:0];
      assign alu_a = alu_result_i[ADDR_WIDTH-1:0];
    end else begin : g_ext
      assign imm_a = {{(ADDR_WIDTH-DATA_WIDTH){imm_i[DATA_WIDTH-1]}}, imm_i};
      assign alu_a = {{(ADDR_WIDTH-DATA_WIDTH){1'b0}}, alu_result_i};
    end
  endgenerate

  always_comb begin
    taken_o  = 1'b0;
    target_o = pc_i + imm_a;
    case (opcode_i)
      INSTR_JAL:  taken_o = 1'b1;
      INSTR_JALR: begin
        taken_o  = 1'b1;
        target_o = alu_a & ~BIT0;
      end
      INSTR_BEQ:  taken_o = eq_i;
      INSTR_BNE:  taken_o = ~eq_i;
      INSTR_BLT:  taken_o = lt_i;
      INSTR_BGE:  taken_o = ~lt_i;
      INSTR_BLTU: taken_o = ltu_i;
      INSTR_BGEU: taken_o = ~ltu_i;
      default:    taken_o = 1'b0;
    endcase
    misaligned_o = taken_o & (|(target_o[1:0] & align_mask(IALIGN)));
  end

endmodule

// File: rtl/pc_unit.sv
// Program-counter unit: fetch PC sequencing, branch/jump redirect, trap entry
// and misaligned-target trap hand-off.
module pc_unit
  import pc_unit_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH   = 32,
  parameter int unsigned           DATA_WIDTH   = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0,
  parameter int unsigned           IALIGN       = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  output logic                  fetch_valid_o,
  input  logic                  fetch_ready_i,
  output logic [ADDR_WIDTH-1:0] fetch_pc_o,
  input  logic                  ex_valid_i,
  input  logic [ADDR_WIDTH-1:0] ex_pc_i,
  input  rv32i_base_instr       ex_opcode_i,
  input  logic [DATA_WIDTH-1:0] ex_imm_i,
  input  logic [DATA_WIDTH-1:0] ex_alu_result_i,
  input  logic                  ex_eq_i,
  input  logic                  ex_lt_i,
  input  logic                  ex_ltu_i,
  output logic [ADDR_WIDTH-1:0] link_addr_o,
  input  logic                  trap_i,
  input  logic [ADDR_WIDTH-1:0] trap_vector_i,
  output logic                  flush_o,
  output logic [ADDR_WIDTH-1:0] redirect_pc_o,
  output logic                  misalign_o,
  output logic [ADDR_WIDTH-1:0] misalign_addr_o
);

  localparam logic [ADDR_WIDTH-1:0] PC_STEP = ADDR_WIDTH'(4);

  pc_state_e             state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic                  misalign_d;
  logic                  flush;
  logic                  taken;
  logic                  misaligned;
  logic [ADDR_WIDTH-1:0] target;
  logic [ADDR_WIDTH-1:0] trap_pc;

  pc_target_calc #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .IALIGN     (IALIGN)
  ) u_target_calc (
    .pc_i         (ex_pc_i),
    .opcode_i     (ex_opcode_i),
    .imm_i        (ex_imm_i),
    .alu_result_i (ex_alu_result_i),
    .eq_i         (ex_eq_i),
    .lt_i         (ex_lt_i),
    .ltu_i        (ex_ltu_i),
    .taken_o      (taken),
    .target_o     (target),
    .misaligned_o (misaligned)
  );

  assign trap_pc       = {trap_vector_i[ADDR_WIDTH-1:2],
                          trap_vector_i[1:0] & ~align_mask(IALIGN)};
  assign link_addr_o   = ex_pc_i + PC_STEP;
  assign fetch_pc_o    = pc_q;
  assign fetch_valid_o = (state_q == RUN);
  // Keep flush quiet while reset is held even if trap_i is already asserted.
  assign flush_o       = flush & rst_ni;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    flush         = 1'b0;
    redirect_pc_o = pc_q;
    misalign_d    = 1'b0;
    if (trap_i) begin
      state_d       = RUN;
      pc_d          = trap_pc;
      flush         = 1'b1;
      redirect_pc_o = trap_pc;
    end else begin
      case (state_q)
        BOOT: state_d = RUN;
        RUN: begin
          if (ex_valid_i && taken) begin
            flush = 1'b1;
            if (misaligned) begin
              state_d    = TRAP_WAIT;
              misalign_d = 1'b1;
            end else begin
              pc_d          = target;
              redirect_pc_o = target;
            end
          end else if (fetch_ready_i) begin
            pc_d = pc_q + PC_STEP;
          end
        end
        TRAP_WAIT: state_d = TRAP_WAIT;
        default:   state_d = BOOT;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q         <= BOOT;
      pc_q            <= RESET_VECTOR;
      misalign_o      <= 1'b0;
      misalign_addr_o <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      misalign_o <= misalign_d;
      if (misalign_d) begin
        misalign_addr_o <= target;
      end
    end
  end

endmodule

// File: tb/tb_pc_unit.sv
// Directed self-checking bench for pc_unit with RESET_VECTOR=0x100, IALIGN=32.
module tb_pc_unit;
  import pc_unit_pkg::*;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            fetch_valid;
  logic            fetch_ready;
  logic [31:0]     fetch_pc;
  logic            ex_valid;
  logic [31:0]     ex_pc;
  rv32i_base_instr ex_opcode;
  logic [31:0]     ex_imm;
  logic [31:0]     ex_alu_result;
  logic            ex_eq, ex_lt, ex_ltu;
  logic [31:0]     link_addr;
  logic            trap;
  logic [31:0]     trap_vector;
  logic            flush;
  logic [31:0]     redirect_pc;
  logic            misalign;
  logic [31:0]     misalign_addr;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  pc_unit #(
    .ADDR_WIDTH   (32),
    .DATA_WIDTH   (32),
    .RESET_VECTOR (32'h0000_0100),
    .IALIGN       (32)
  ) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .fetch_valid_o   (fetch_valid),
    .fetch_ready_i   (fetch_ready),
    .fetch_pc_o      (fetch_pc),
    .ex_valid_i      (ex_valid),
    .ex_pc_i         (ex_pc),
    .ex_opcode_i     (ex_opcode),
    .ex_imm_i        (ex_imm),
    .ex_alu_result_i (ex_alu_result),
    .ex_eq_i         (ex_eq),
    .ex_lt_i         (ex_lt),
    .ex_ltu_i        (ex_ltu),
    .link_addr_o     (link_addr),
    .trap_i          (trap),
    .trap_vector_i   (trap_vector),
    .flush_o         (flush),
    .redirect_pc_o   (redirect_pc),
    .misalign_o      (misalign),
    .misalign_addr_o (misalign_addr)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  typedef struct {
    rv32i_base_instr op;
    logic eq, lt, ltu, taken;
  } br_vec_t;

  br_vec_t br_tbl[10] = '{
    '{INSTR_BEQ,  1'b0, 1'b0, 1'b0, 1'b0},
    '{INSTR_BNE,  1'b0, 1'b0, 1'b0, 1'b1},
    '{INSTR_BNE,  1'b1, 1'b0, 1'b0, 1'b0},
    '{INSTR_BLT,  1'b0, 1'b1, 1'b0, 1'b1},
    '{INSTR_BGE,  1'b0, 1'b1, 1'b0, 1'b0},
    '{INSTR_BGE,  1'b0, 1'b0, 1'b1, 1'b1},
    '{INSTR_BLTU, 1'b0, 1'b1, 1'b0, 1'b0},
    '{INSTR_BGEU, 1'b1, 1'b0, 1'b1, 1'b0},
    '{INSTR_ADD,  1'b1, 1'b1, 1'b1, 1'b0},
    '{INSTR_JAL,  1'b0, 1'b0, 1'b0, 1'b1}
  };

  initial begin
    rst_n = 1'b0; fetch_ready = 1'b1; ex_valid = 1'b0; ex_pc = '0;
    ex_opcode = INSTR_ADDI; ex_imm = '0; ex_alu_result = '0;
    ex_eq = 1'b0; ex_lt = 1'b0; ex_ltu = 1'b0;
    trap = 1'b1; trap_vector = 32'h0000_0040;

    // Reset state, with trap_i asserted to show flush is suppressed
    #12;
    check("rst_valid", {31'b0, fetch_valid}, 32'd0);
    check("rst_pc", fetch_pc, 32'h100);
    check("rst_misalign", {31'b0, misalign}, 32'd0);
    check("rst_mis_addr", misalign_addr, 32'h0);
    check("rst_flush", {31'b0, flush}, 32'd0);
    trap = 1'b0;

    // Boot sequence
    rst_n = 1'b1;
    #1;
    check("boot_valid", {31'b0, fetch_valid}, 32'd0);
    tick();
    check("run_valid", {31'b0, fetch_valid}, 32'd1);
    check("seq_pc0", fetch_pc, 32'h100);
    tick();
    check("seq_pc1", fetch_pc, 32'h104);
    tick();
    check("seq_pc2", fetch_pc, 32'h108);

    // Taken BEQ overrides the concurrent fetch handshake
    ex_valid = 1'b1; ex_opcode = INSTR_BEQ; ex_eq = 1'b1;
    ex_pc = 32'h200; ex_imm = 32'h40;
    #1;
    check("beq_flush", {31'b0, flush}, 32'd1);
    check("beq_redirect", redirect_pc, 32'h240);
    check("link_addr", link_addr, 32'h204);
    tick();
    check("beq_pc", fetch_pc, 32'h240);
    ex_eq = 1'b0;
    #1;
    check("beq_nt_flush", {31'b0, flush}, 32'd0);
    tick();
    check("beq_nt_pc", fetch_pc, 32'h244);

    // Negative immediate
    ex_opcode = INSTR_BNE; ex_imm = 32'hFFFF_FFF0;
    #1;
    check("bne_neg_redirect", redirect_pc, 32'h1F0);
    tick();
    check("bne_neg_pc", fetch_pc, 32'h1F0);

    // Taken-condition table (targets all 0x240, aligned)
    ex_imm = 32'h40;
    foreach (br_tbl[i]) begin
      ex_opcode = br_tbl[i].op; ex_eq = br_tbl[i].eq;
      ex_lt = br_tbl[i].lt; ex_ltu = br_tbl[i].ltu;
      #1;
      check($sformatf("tbl%0d_flush", i), {31'b0, flush}, {31'b0, br_tbl[i].taken});
      if (br_tbl[i].taken) check($sformatf("tbl%0d_redir", i), redirect_pc, 32'h240);
    end
    ex_valid = 1'b0;

    // Known PC via trap, then misaligned JALR
    tick();
    trap = 1'b1; trap_vector = 32'h400;
    tick();
    trap = 1'b0;
    check("trap_pc", fetch_pc, 32'h400);
    ex_valid = 1'b1; ex_opcode = INSTR_JALR; ex_alu_result = 32'h303;
    #1;
    check("jalr_flush", {31'b0, flush}, 32'd1);
    check("jalr_redirect_hold", redirect_pc, 32'h400);
    tick();
    check("mis_pulse", {31'b0, misalign}, 32'd1);
    check("mis_addr", misalign_addr, 32'h302);
    check("mis_valid", {31'b0, fetch_valid}, 32'd0);
    check("mis_pc_hold", fetch_pc, 32'h400);
    check("tw_ex_ignored", {31'b0, flush}, 32'd0);
    tick();
    check("mis_pulse_end", {31'b0, misalign}, 32'd0);
    check("tw_valid", {31'b0, fetch_valid}, 32'd0);
    trap = 1'b1; trap_vector = 32'h83;
    #1;
    check("tw_trap_flush", {31'b0, flush}, 32'd1);
    check("tw_trap_redirect", redirect_pc, 32'h80);
    tick();
    trap = 1'b0; ex_valid = 1'b0;
    check("tw_exit_valid", {31'b0, fetch_valid}, 32'd1);
    check("tw_exit_pc", fetch_pc, 32'h80);

    // Trap beats a same-cycle taken JAL
    trap = 1'b1; trap_vector = 32'h500;
    ex_valid = 1'b1; ex_opcode = INSTR_JAL; ex_pc = 32'h200; ex_imm = 32'h40;
    #1;
    check("trap_jal_flush", {31'b0, flush}, 32'd1);
    check("trap_jal_redirect", redirect_pc, 32'h500);
    tick();
    trap = 1'b0; ex_valid = 1'b0;
    check("trap_jal_pc", fetch_pc, 32'h500);
    check("trap_jal_nomis", {31'b0, misalign}, 32'd0);

    // Wrap and hold
    trap = 1'b1; trap_vector = 32'hFFFF_FFFC;
    tick();
    trap = 1'b0; fetch_ready = 1'b0;
    check("wrap_start", fetch_pc, 32'hFFFF_FFFC);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("hold%0d", i), fetch_pc, 32'hFFFF_FFFC);
    end
    fetch_ready = 1'b1;
    tick();
    check("wrap_pc", fetch_pc, 32'h0);
    ex_pc = 32'hFFFF_FFFC;
    #1;
    check("link_wrap", link_addr, 32'h0);

    // Reset during TRAP_WAIT while the misalign pulse is high
    ex_valid = 1'b1; ex_opcode = INSTR_JALR; ex_alu_result = 32'h303;
    tick();
    ex_valid = 1'b0;
    check("pre_rst_mis", {31'b0, misalign}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("arst_valid", {31'b0, fetch_valid}, 32'd0);
    check("arst_pc", fetch_pc, 32'h100);
    check("arst_mis", {31'b0, misalign}, 32'd0);
    check("arst_mis_addr", misalign_addr, 32'h0);
    check("arst_flush", {31'b0, flush}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("reboot_valid", {31'b0, fetch_valid}, 32'd0);
    tick();
    check("reboot_pc0", fetch_pc, 32'h100);
    check("reboot_run", {31'b0, fetch_valid}, 32'd1);
    tick();
    check("reboot_pc1", fetch_pc, 32'h104);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
